// File: rtl/mmio_mon_pkg.sv
// Shared types, channel addresses and helpers for the MMIO store-to-output latency monitor.
package mmio_mon_pkg;

   typedef enum logic {MON_IDLE, MON_WAIT} mon_state_e;

   localparam logic [31:0] ADDR_LEDR = 32'h0000_7000;
   localparam logic [31:0] ADDR_LEDG = 32'h0000_7010;

   // Saturating increment on a counter zero-extended to 32 bits; max is the
   // all-ones value of the real counter width, so counters up to 32 bits are covered.
   function automatic logic [31:0] sat_inc(input logic [31:0] cnt, input logic [31:0] max);
      return (cnt == max) ? cnt : cnt + 32'd1;
   endfunction

endpackage

// File: rtl/mmio_lat_ch.sv
// One monitored channel: IDLE/WAIT FSM, expected value, cycle timer and
// saturating ok/late/overrun counters.
module mmio_lat_ch
   import mmio_mon_pkg::*;
#(
   parameter int DATA_W  = 32,
   parameter int MAX_LAT = 4,
   parameter int CNT_W   = 16
) (
   input  logic              clk,
   input  logic              rstn,
   input  logic              i_clr,
   input  logic              i_hit,
   input  logic [DATA_W-1:0] i_wdata,
   input  logic [DATA_W-1:0] i_obs,
   output logic              o_pending,
   output logic              o_late_pulse,
   output logic              o_late_sticky,
   output logic [CNT_W-1:0]  o_ok_cnt,
   output logic [CNT_W-1:0]  o_late_cnt,
   output logic [CNT_W-1:0]  o_ovr_cnt
);

   localparam logic [7:0]       MAX_T   = 8'(MAX_LAT);
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   mon_state_e        state_q, state_d;
   logic [DATA_W-1:0] exp_q, exp_d;
   logic [7:0]        tmr_q, tmr_d;
   logic [CNT_W-1:0]  ok_cnt_q, ok_cnt_d;
   logic [CNT_W-1:0]  late_cnt_q, late_cnt_d;
   logic [CNT_W-1:0]  ovr_cnt_q, ovr_cnt_d;
   logic              late_pulse_q, late_pulse_d;
   logic              late_sticky_q, late_sticky_d;

   logic waiting, match, timeout;

   assign waiting = (state_q == MON_WAIT);
   assign match   = waiting && (i_obs == exp_q);
   assign timeout = waiting && !match && (tmr_q == MAX_T);

   // State register: synchronous active-low reset, then clear, both back to IDLE with zeroed counters.
   always_ff @(posedge clk) begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values regardless of statement order.
      if (!rstn || i_clr) begin
         state_q       <= MON_IDLE;
         exp_q         <= '0;
         tmr_q         <= '0;
         ok_cnt_q      <= '0;
         late_cnt_q    <= '0;
         ovr_cnt_q     <= '0;
         late_pulse_q  <= 1'b0;
         late_sticky_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         exp_q         <= exp_d;
         tmr_q         <= tmr_d;
         ok_cnt_q      <= ok_cnt_d;
         late_cnt_q    <= late_cnt_d;
         ovr_cnt_q     <= ovr_cnt_d;
         late_pulse_q  <= late_pulse_d;
         late_sticky_q <= late_sticky_d;
      end
   end

   // Next state: resolve match/timeout on the old expectation first, then let a hit re-arm.
   always_comb begin
      // NOTE: every _d gets a hold/idle default first so no path leaves it unassigned (no latch).
      state_d       = state_q;
      exp_d         = exp_q;
      tmr_d         = tmr_q;
      ok_cnt_d      = ok_cnt_q;
      late_cnt_d    = late_cnt_q;
      ovr_cnt_d     = ovr_cnt_q;
      late_pulse_d  = 1'b0;
      late_sticky_d = late_sticky_q;

      if (waiting) begin
         if (match) begin
            ok_cnt_d = CNT_W'(sat_inc(32'(ok_cnt_q), 32'(CNT_MAX)));
            state_d  = MON_IDLE;
         end else if (timeout) begin
            late_cnt_d    = CNT_W'(sat_inc(32'(late_cnt_q), 32'(CNT_MAX)));
            late_sticky_d = 1'b1;
            late_pulse_d  = 1'b1;
            state_d       = MON_IDLE;
         end else begin
            tmr_d = tmr_q + 8'd1;
         end
      end

      if (i_hit) begin
         if (waiting && !match && !timeout) begin
            ovr_cnt_d = CNT_W'(sat_inc(32'(ovr_cnt_q), 32'(CNT_MAX)));
         end
         exp_d   = i_wdata;
         tmr_d   = 8'd1;
         state_d = MON_WAIT;
      end
   end

   // Outputs: all straight from registers.
   always_comb begin
      o_pending     = waiting;
      o_late_pulse  = late_pulse_q;
      o_late_sticky = late_sticky_q;
      o_ok_cnt      = ok_cnt_q;
      o_late_cnt    = late_cnt_q;
      o_ovr_cnt     = ovr_cnt_q;
   end

endmodule

// File: rtl/mmio_latency_monitor.sv
// Snoops LSU stores and per-channel output registers; checks that each
// channel output reflects a stored value within MAX_LAT cycles.
module mmio_latency_monitor
   import mmio_mon_pkg::*;
#(
   parameter int                          NUM_CH  = 2,
   parameter int                          ADDR_W  = 32,
   parameter int                          DATA_W  = 32,
   parameter int                          MAX_LAT = 4,
   parameter int                          CNT_W   = 16,
   parameter logic [NUM_CH*ADDR_W-1:0]    CH_ADDR = {ADDR_LEDG, ADDR_LEDR}
) (
   input  logic                      clk,
   input  logic                      rstn,
   input  logic                      i_st_vld,
   input  logic [ADDR_W-1:0]         i_st_addr,
   input  logic [DATA_W-1:0]         i_st_wdata,
   input  logic [NUM_CH*DATA_W-1:0]  i_obs,
   input  logic                      i_clr,
   output logic [NUM_CH-1:0]         o_pending,
   output logic [NUM_CH-1:0]         o_late_pulse,
   output logic [NUM_CH-1:0]         o_late_sticky,
   output logic [NUM_CH*CNT_W-1:0]   o_ok_cnt,
   output logic [NUM_CH*CNT_W-1:0]   o_late_cnt,
   output logic [NUM_CH*CNT_W-1:0]   o_ovr_cnt,
   output logic                      o_any_err
);

   // The channel timer is 8 bits wide, so the latency window must fit in it.
   if (MAX_LAT < 1 || MAX_LAT > 255) begin : g_bad_max_lat
      $error("mmio_latency_monitor: MAX_LAT must be in 1..255");
   end

   logic [NUM_CH-1:0] hit;

   // Address decode: exact full-width compare against each channel address.
   always_comb begin
      for (int c = 0; c < NUM_CH; c++) begin
         hit[c] = i_st_vld && (i_st_addr == CH_ADDR[c*ADDR_W +: ADDR_W]);
      end
   end

   for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
      mmio_lat_ch #(
         .DATA_W  (DATA_W),
         .MAX_LAT (MAX_LAT),
         .CNT_W   (CNT_W)
      ) u_ch (
         .clk           (clk),
         .rstn          (rstn),
         .i_clr         (i_clr),
         .i_hit         (hit[c]),
         .i_wdata       (i_st_wdata),
         .i_obs         (i_obs[c*DATA_W +: DATA_W]),
         .o_pending     (o_pending[c]),
         .o_late_pulse  (o_late_pulse[c]),
         .o_late_sticky (o_late_sticky[c]),
         .o_ok_cnt      (o_ok_cnt[c*CNT_W +: CNT_W]),
         .o_late_cnt    (o_late_cnt[c*CNT_W +: CNT_W]),
         .o_ovr_cnt     (o_ovr_cnt[c*CNT_W +: CNT_W])
      );
   end

   assign o_any_err = |o_late_sticky;

endmodule

// File: tb/tb_mmio_latency_monitor.sv
// Directed bench for mmio_latency_monitor; a second instance with CNT_W=2
// shares the stimulus and is used for the saturation scenario.
module tb_mmio_latency_monitor;

   localparam int NUM_CH = 2;
   localparam int DW     = 32;
   localparam int CW     = 16;
   localparam int CW2    = 2;

   logic              clk = 1'b0;
   logic              rstn = 1'b0;
   logic              st_vld = 1'b0;
   logic [31:0]       st_addr = '0;
   logic [DW-1:0]     st_wdata = '0;
   logic [DW-1:0]     obs0 = '0, obs1 = '0;
   logic              clr = 1'b0;

   logic [NUM_CH-1:0]      pending, late_pulse, late_sticky;
   logic [NUM_CH*CW-1:0]   ok_cnt, late_cnt, ovr_cnt;
   logic                   any_err;

   logic [NUM_CH-1:0]      s_pending, s_late_pulse, s_late_sticky;
   logic [NUM_CH*CW2-1:0]  s_ok_cnt, s_late_cnt, s_ovr_cnt;
   logic                   s_any_err;

   int vectors = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   mmio_latency_monitor dut (
      .clk           (clk),
      .rstn          (rstn),
      .i_st_vld      (st_vld),
      .i_st_addr     (st_addr),
      .i_st_wdata    (st_wdata),
      .i_obs         ({obs1, obs0}),
      .i_clr         (clr),
      .o_pending     (pending),
      .o_late_pulse  (late_pulse),
      .o_late_sticky (late_sticky),
      .o_ok_cnt      (ok_cnt),
      .o_late_cnt    (late_cnt),
      .o_ovr_cnt     (ovr_cnt),
      .o_any_err     (any_err)
   );

   mmio_latency_monitor #(.CNT_W(CW2)) dut_sat (
      .clk           (clk),
      .rstn          (rstn),
      .i_st_vld      (st_vld),
      .i_st_addr     (st_addr),
      .i_st_wdata    (st_wdata),
      .i_obs         ({obs1, obs0}),
      .i_clr         (clr),
      .o_pending     (s_pending),
      .o_late_pulse  (s_late_pulse),
      .o_late_sticky (s_late_sticky),
      .o_ok_cnt      (s_ok_cnt),
      .o_late_cnt    (s_late_cnt),
      .o_ovr_cnt     (s_ovr_cnt),
      .o_any_err     (s_any_err)
   );

   // Packed view of one channel's three counters: {ok, late, ovr}.
   function automatic logic [47:0] cnts(input int c);
      return {ok_cnt[c*CW +: CW], late_cnt[c*CW +: CW], ovr_cnt[c*CW +: CW]};
   endfunction

   // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
   task automatic tick(input int n = 1);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic store(input logic [31:0] addr, input logic [DW-1:0] data);
      st_vld = 1'b1; st_addr = addr; st_wdata = data;
      tick();
      st_vld = 1'b0; st_addr = '0; st_wdata = '0;
   endtask

   task automatic do_clear();
      clr = 1'b1;
      tick();
      clr = 1'b0;
   endtask

   task automatic test_reset();
      rstn = 1'b0;
      tick(2);
      vectors++;
      if ({pending, late_pulse, late_sticky, any_err} !== 7'b0) begin
         miscompares++;
         $display("FAIL reset_flags: got %b want 0", {pending, late_pulse, late_sticky, any_err});
      end
      vectors++;
      if ({ok_cnt, late_cnt, ovr_cnt} !== '0) begin
         miscompares++;
         $display("FAIL reset_cnts: got %h want 0", {ok_cnt, late_cnt, ovr_cnt});
      end
      rstn = 1'b1;
      tick();
   endtask

   task automatic test_ok_match();
      obs0 = '0;
      store(32'h0000_7000, 32'h1);
      vectors++;
      if (pending !== 2'b01) begin
         miscompares++;
         $display("FAIL ok_pend_c1: got %b want 01", pending);
      end
      tick();
      vectors++;
      if (pending !== 2'b01) begin
         miscompares++;
         $display("FAIL ok_pend_c2: got %b want 01", pending);
      end
      obs0 = 32'h1;
      tick();
      vectors++;
      if ({pending, any_err, cnts(0)} !== {2'b00, 1'b0, 16'd1, 16'd0, 16'd0}) begin
         miscompares++;
         $display("FAIL ok_done: got pend=%b err=%b cnt=%h want pend=00 err=0 cnt=000100000000",
                  pending, any_err, cnts(0));
      end
   endtask

   task automatic test_timeout();
      obs1 = '0;
      store(32'h0000_7010, 32'h2);
      tick(3);
      vectors++;
      if ({pending, late_pulse} !== {2'b10, 2'b00}) begin
         miscompares++;
         $display("FAIL late_before: got pend=%b pulse=%b want pend=10 pulse=00", pending, late_pulse);
      end
      tick();
      vectors++;
      if ({pending, late_pulse, late_sticky, any_err, cnts(1)} !==
          {2'b00, 2'b10, 2'b10, 1'b1, 16'd0, 16'd1, 16'd0}) begin
         miscompares++;
         $display("FAIL late_fire: got pend=%b pulse=%b sticky=%b err=%b cnt=%h want 00 10 10 1 000000010000",
                  pending, late_pulse, late_sticky, any_err, cnts(1));
      end
      tick();
      vectors++;
      if ({late_pulse, late_sticky} !== {2'b00, 2'b10}) begin
         miscompares++;
         $display("FAIL late_pulse_once: got pulse=%b sticky=%b want 00 10", late_pulse, late_sticky);
      end
   endtask

   task automatic test_miss();
      store(32'h0000_7004, 32'h5);
      obs0 = 32'h5;
      obs1 = 32'h5;
      tick(2);
      vectors++;
      if ({pending, cnts(0)} !== {2'b00, 16'd1, 16'd0, 16'd0}) begin
         miscompares++;
         $display("FAIL miss: got pend=%b cnt0=%h want 00 000100000000", pending, cnts(0));
      end
   endtask

   task automatic test_overrun();
      do_clear();
      vectors++;
      if ({any_err, late_sticky, cnts(1)} !== '0) begin
         miscompares++;
         $display("FAIL clr_idle: got err=%b sticky=%b cnt1=%h want 0", any_err, late_sticky, cnts(1));
      end
      obs0 = '0;
      store(32'h0000_7000, 32'hA);
      tick();
      store(32'h0000_7000, 32'hB);
      obs0 = 32'hB;
      tick();
      vectors++;
      if ({pending[0], cnts(0)} !== {1'b0, 16'd1, 16'd0, 16'd1}) begin
         miscompares++;
         $display("FAIL ovr: got pend0=%b cnt0=%h want 0 000100000001", pending[0], cnts(0));
      end
   endtask

   task automatic test_match_rearm();
      do_clear();
      obs0 = '0;
      store(32'h0000_7000, 32'hA);
      tick();
      obs0 = 32'hA;
      store(32'h0000_7000, 32'hB);
      vectors++;
      if ({pending[0], cnts(0)} !== {1'b1, 16'd1, 16'd0, 16'd0}) begin
         miscompares++;
         $display("FAIL rearm_match: got pend0=%b cnt0=%h want 1 000100000000", pending[0], cnts(0));
      end
      obs0 = 32'hB;
      tick();
      vectors++;
      if ({pending[0], cnts(0)} !== {1'b0, 16'd2, 16'd0, 16'd0}) begin
         miscompares++;
         $display("FAIL rearm_second: got pend0=%b cnt0=%h want 0 000200000000", pending[0], cnts(0));
      end
   endtask

   task automatic test_boundary();
      do_clear();
      obs0 = '0;
      store(32'h0000_7000, 32'h5);
      tick(3);
      obs0 = 32'h5;
      tick();
      vectors++;
      if ({pending[0], late_pulse[0], cnts(0)} !== {1'b0, 1'b0, 16'd1, 16'd0, 16'd0}) begin
         miscompares++;
         $display("FAIL edge_ok: got pend0=%b pulse0=%b cnt0=%h want 0 0 000100000000",
                  pending[0], late_pulse[0], cnts(0));
      end
      store(32'h0000_7000, 32'h6);
      tick(4);
      obs0 = 32'h6;
      vectors++;
      if ({late_pulse[0], cnts(0)} !== {1'b1, 16'd1, 16'd1, 16'd0}) begin
         miscompares++;
         $display("FAIL edge_late: got pulse0=%b cnt0=%h want 1 000100010000", late_pulse[0], cnts(0));
      end
      tick();
      vectors++;
      if ({pending[0], late_pulse[0], cnts(0)} !== {1'b0, 1'b0, 16'd1, 16'd1, 16'd0}) begin
         miscompares++;
         $display("FAIL edge_after: got pend0=%b pulse0=%b cnt0=%h want 0 0 000100010000",
                  pending[0], late_pulse[0], cnts(0));
      end
   endtask

   task automatic test_back_to_back();
      do_clear();
      obs0 = '0;
      obs1 = '0;
      store(32'h0000_7000, 32'h11);
      store(32'h0000_7010, 32'h22);
      vectors++;
      if (pending !== 2'b11) begin
         miscompares++;
         $display("FAIL b2b_pend: got %b want 11", pending);
      end
      // Clear mid-WAIT together with a store that must be ignored.
      clr = 1'b1;
      st_vld = 1'b1; st_addr = 32'h0000_7000; st_wdata = 32'h33;
      tick();
      clr = 1'b0;
      st_vld = 1'b0;
      vectors++;
      if ({pending, late_pulse, late_sticky, ok_cnt, late_cnt, ovr_cnt} !== '0) begin
         miscompares++;
         $display("FAIL clr_mid: got pend=%b pulse=%b sticky=%b cnts=%h want all 0",
                  pending, late_pulse, late_sticky, {ok_cnt, late_cnt, ovr_cnt});
      end
      tick(5);
      vectors++;
      if ({pending, late_pulse, late_cnt} !== '0) begin
         miscompares++;
         $display("FAIL clr_quiet: got pend=%b pulse=%b late=%h want 0", pending, late_pulse, late_cnt);
      end
      // Build a sticky error and a pending channel, then reset while busy.
      store(32'h0000_7010, 32'h44);
      tick(4);
      store(32'h0000_7000, 32'h55);
      vectors++;
      if ({pending[0], any_err} !== 2'b11) begin
         miscompares++;
         $display("FAIL pre_rst: got pend0=%b err=%b want 1 1", pending[0], any_err);
      end
      rstn = 1'b0;
      tick();
      vectors++;
      if ({pending, late_pulse, late_sticky, any_err, ok_cnt, late_cnt, ovr_cnt} !== '0) begin
         miscompares++;
         $display("FAIL rst_busy: got pend=%b pulse=%b sticky=%b err=%b cnts=%h want all 0",
                  pending, late_pulse, late_sticky, any_err, {ok_cnt, late_cnt, ovr_cnt});
      end
      rstn = 1'b1;
      tick();
   endtask

   task automatic test_saturate();
      do_clear();
      for (int i = 0; i < 5; i++) begin
         store(32'h0000_7000, 32'h100 + 32'(i));
         obs0 = 32'h100 + 32'(i);
         tick();
      end
      vectors++;
      if (ok_cnt[CW-1:0] !== 16'd5) begin
         miscompares++;
         $display("FAIL sat_wide: got %0d want 5", ok_cnt[CW-1:0]);
      end
      vectors++;
      if (s_ok_cnt[CW2-1:0] !== 2'd3) begin
         miscompares++;
         $display("FAIL sat_narrow: got %0d want 3", s_ok_cnt[CW2-1:0]);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      tick();
      test_reset();
      test_ok_match();
      test_timeout();
      test_miss();
      test_overrun();
      test_match_rearm();
      test_boundary();
      test_back_to_back();
      test_saturate();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
